step_controller: RTL and testbench

Converts the raw board controls (step button, instruction/cycle switch, step/run switch, breakpoint enable) into a single-cycle CPU clock-enable stream for the datapath. It sits between the board pins and the datapath core in the 5 MHz oscillator domain. It synchronises and debounces the inputs, runs the run/halt/step state machine, and halts on a breakpoint address match at instruction boundaries.

---
 rtl/step_controller_pkg.sv | 16 +
 rtl/step_controller_debouncer.sv | 45 ++++
 rtl/step_controller.sv | 146 ++++++++++++++
 tb/tb_step_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/step_controller_pkg.sv
// Shared definitions for the step controller: FSM state encoding and
// default parameter values.
package step_controller_pkg;

    typedef enum logic [1:0] {
        HALT       = 2'd0,
        RUN        = 2'd1,
        STEP_CYCLE = 2'd2,
        STEP_INSTR = 2'd3
    } state_t;

    // 10 ms of stability at 5 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int unsigned ADDR_WIDTH_DEFAULT      = 16;

endpackage

// File: rtl/step_controller_debouncer.sv
// Two-flop synchroniser followed by a stability counter. The stable value
// only follows the synchronised input after it has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles.
module debouncer
    import step_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;

    // Synchronise the raw pin, then count cycles of disagreement with the stable value
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != stable) begin
                if (count == LAST) begin
                    stable <= sync2;
                    count  <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/step_controller.sv
// Turns the board step/run/breakpoint controls into a per-cycle CPU clock
// enable. Inputs are synchronised and debounced, then a run/halt/step FSM
// gates the enable and parks the CPU on breakpoints at instruction starts.
module step_controller
    import step_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEFAULT
) (
    input  logic                  i_oszClk,
    input  logic                  i_reset,
    input  logic                  i_btnStep,
    input  logic                  i_swInstrNCycle,
    input  logic                  i_swStepNRun,
    input  logic                  i_swEnableBreakpoint,
    input  logic [ADDR_WIDTH-1:0] i_breakpointAddress,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_instrStart,
    output logic                  o_cpuClkEn,
    output logic                  o_halted,
    output logic                  o_breakpointHit
);

    logic   step_db;
    logic   instr_n_cycle_db;
    logic   step_n_run_db;
    logic   bp_enable_db;
    logic   step_db_q;
    logic   step_req;
    logic   bp_mask;
    logic   bp_match;
    logic   cpu_clk_en;
    state_t state;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk    (i_oszClk),
        .reset  (i_reset),
        .raw    (i_btnStep),
        .stable (step_db)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_instr_n_cycle (
        .clk    (i_oszClk),
        .reset  (i_reset),
        .raw    (i_swInstrNCycle),
        .stable (instr_n_cycle_db)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step_n_run (
        .clk    (i_oszClk),
        .reset  (i_reset),
        .raw    (i_swStepNRun),
        .stable (step_n_run_db)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_bp_enable (
        .clk    (i_oszClk),
        .reset  (i_reset),
        .raw    (i_swEnableBreakpoint),
        .stable (bp_enable_db)
    );

    assign step_req   = step_db && !step_db_q;
    assign o_cpuClkEn = cpu_clk_en;

    // Breakpoint compare and clock enable, combinational so the datapath is
    // stopped in the very cycle the halt condition is seen
    always_comb begin
        cpu_clk_en = 1'b0;
        bp_match   = bp_enable_db && i_instrStart && !bp_mask &&
                     (i_pc == i_breakpointAddress);
        unique case (state)
            HALT:       cpu_clk_en = 1'b0;
            RUN:        cpu_clk_en = !step_n_run_db && !bp_match;
            STEP_CYCLE: cpu_clk_en = 1'b1;
            STEP_INSTR: cpu_clk_en = !(i_instrStart && !bp_mask);
            default:    cpu_clk_en = 1'b0;
        endcase
    end

    // Run/halt/step FSM with registered status outputs; bpMask lets the CPU
    // step off the boundary it is parked on before compares are honoured
    always_ff @(posedge i_oszClk) begin
        if (i_reset) begin
            state           <= HALT;
            o_halted        <= 1'b1;
            o_breakpointHit <= 1'b0;
            bp_mask         <= 1'b0;
            step_db_q       <= 1'b0;
        end else begin
            step_db_q <= step_db;
            if (cpu_clk_en) begin
                bp_mask <= 1'b0;
            end
            unique case (state)
                HALT: begin
                    if (!step_n_run_db) begin
                        if (!o_breakpointHit) begin
                            state    <= RUN;
                            o_halted <= 1'b0;
                            bp_mask  <= 1'b1;
                        end else if (step_req) begin
                            state           <= RUN;
                            o_halted        <= 1'b0;
                            o_breakpointHit <= 1'b0;
                            bp_mask         <= 1'b1;
                        end
                    end else if (step_req) begin
                        state    <= instr_n_cycle_db ? STEP_INSTR : STEP_CYCLE;
                        o_halted <= 1'b0;
                        bp_mask  <= 1'b1;
                    end
                end
                RUN: begin
                    if (step_n_run_db) begin
                        state    <= HALT;
                        o_halted <= 1'b1;
                    end else if (bp_match) begin
                        state           <= HALT;
                        o_halted        <= 1'b1;
                        o_breakpointHit <= 1'b1;
                    end
                end
                STEP_CYCLE: begin
                    state    <= HALT;
                    o_halted <= 1'b1;
                end
                STEP_INSTR: begin
                    if (bp_match) begin
                        state           <= HALT;
                        o_halted        <= 1'b1;
                        o_breakpointHit <= 1'b1;
                    end else if (i_instrStart && !bp_mask) begin
                        state    <= HALT;
                        o_halted <= 1'b1;
                    end
                end
                default: begin
                    state    <= HALT;
                    o_halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller with DEBOUNCE_CYCLES = 4. Stimulus pushes the
// cycle numbers at which enable pulses must appear; a monitor pops one per
// observed pulse. A tiny CPU model advances a microcycle counter on enable,
// with an instruction start every 4th microcycle and PC = 0x20 + uc/4.
module tb_step_controller;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_btnStep = 1'b0;
    logic        i_swInstrNCycle = 1'b0;
    logic        i_swStepNRun = 1'b1;
    logic        i_swEnableBreakpoint = 1'b0;
    logic [15:0] i_breakpointAddress = 16'h0028;
    logic [15:0] i_pc;
    logic        i_instrStart;
    logic        o_cpuClkEn;
    logic        o_halted;
    logic        o_breakpointHit;

    int   cyc = 0;
    int   uc = 0;
    logic en_s = 1'b0;
    logic model_load = 1'b1;
    int   model_val = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_q[$];

    step_controller #(.DEBOUNCE_CYCLES(4), .ADDR_WIDTH(16)) dut (
        .i_oszClk             (clk),
        .i_reset              (i_reset),
        .i_btnStep            (i_btnStep),
        .i_swInstrNCycle      (i_swInstrNCycle),
        .i_swStepNRun         (i_swStepNRun),
        .i_swEnableBreakpoint (i_swEnableBreakpoint),
        .i_breakpointAddress  (i_breakpointAddress),
        .i_pc                 (i_pc),
        .i_instrStart         (i_instrStart),
        .o_cpuClkEn           (o_cpuClkEn),
        .o_halted             (o_halted),
        .o_breakpointHit      (o_breakpointHit)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) en_s <= o_cpuClkEn;

    always @(posedge clk) begin
        if (model_load) uc <= model_val;
        else if (en_s)  uc <= uc + 1;
    end

    assign i_instrStart = (uc % 4) == 0;
    assign i_pc         = 16'h0020 + 16'(uc / 4);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        int e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0] < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL en_missing: no enable seen, expected at cycle %0d (now %0d)", e, cyc);
            end
            if (o_cpuClkEn) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL en_unexpected: enable at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("en_pulse_cycle", cyc, e);
                end
            end
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_range(input int first, input int last);
        for (int k = first; k <= last; k++) exp_q.push_back(k);
    endtask

    task automatic park();
        model_val  = 0;
        model_load = 1'b1;
        @(negedge clk);
        model_load = 1'b0;
    endtask

    // Called at a negedge while reset is held: check reset outputs, release.
    // Debounced StepNRun restarts at 0, so the FSM runs for 5 cycles first.
    task automatic reset_release();
        int r;
        r = cyc;
        check("reset_en", o_cpuClkEn, 0);
        check("reset_halted", o_halted, 1);
        check("reset_bphit", o_breakpointHit, 0);
        i_reset = 1'b0;
        push_range(r + 1, r + 5);
    endtask

    initial begin
        int c;
        fork
            monitor();
        join_none

        // Reset, then step mode held: halted, no enables
        repeat (3) @(negedge clk);
        reset_release();
        model_load = 1'b0;
        goto(cyc + 8);
        for (int k = 0; k < 100; k++) begin
            check("idle_halted", o_halted, 1);
            @(negedge clk);
        end

        // Cycle step: one pulse 7 cycles after the press
        c = cyc;
        i_btnStep = 1'b1;
        exp_q.push_back(c + 7);
        goto(c + 7);
        check("cstep_halted_during", o_halted, 0);
        goto(c + 8);
        check("cstep_halted_after", o_halted, 1);
        goto(c + 10);
        i_btnStep = 1'b0;
        goto(c + 25);

        // Bouncing press: 3-cycle pulses never settle
        for (int k = 0; k < 4; k++) begin
            i_btnStep = 1'b1;
            repeat (3) @(negedge clk);
            i_btnStep = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("bounce_halted", o_halted, 1);

        // Instruction step from a parked boundary: 4 enables then halt
        i_swInstrNCycle = 1'b1;
        repeat (8) @(negedge clk);
        park();
        c = cyc;
        i_btnStep = 1'b1;
        push_range(c + 7, c + 10);
        goto(c + 10);
        i_btnStep = 1'b0;
        goto(c + 11);
        check("istep_halted_lag", o_halted, 0);
        goto(c + 12);
        check("istep_halted", o_halted, 1);
        goto(c + 20);

        // Breakpoint at 0x0028 in run mode
        i_swEnableBreakpoint = 1'b1;
        repeat (8) @(negedge clk);
        park();
        c = cyc;
        i_swStepNRun = 1'b0;
        push_range(c + 7, c + 38);
        goto(c + 39);
        check("bp_pc", i_pc, 16'h0028);
        check("bp_halted_lag", o_halted, 0);
        check("bp_hit_lag", o_breakpointHit, 0);
        goto(c + 40);
        check("bp_halted", o_halted, 1);
        check("bp_hit", o_breakpointHit, 1);
        goto(c + 50);
        check("bp_parked", o_halted, 1);

        // Resume from breakpoint with a step press, no re-halt at 0x0028
        c = cyc;
        i_btnStep = 1'b1;
        push_range(c + 7, c + 25);
        goto(c + 8);
        check("resume_bphit_clr", o_breakpointHit, 0);
        check("resume_running", o_halted, 0);
        goto(c + 10);
        i_btnStep = 1'b0;
        goto(c + 20);
        i_swStepNRun = 1'b1;
        goto(c + 28);
        check("resume_halted", o_halted, 1);
        check("resume_bphit", o_breakpointHit, 0);

        // Reset in the middle of an instruction step
        i_swEnableBreakpoint = 1'b0;
        repeat (8) @(negedge clk);
        park();
        c = cyc;
        i_btnStep = 1'b1;
        push_range(c + 7, c + 8);
        goto(c + 8);
        i_reset = 1'b1;
        i_btnStep = 1'b0;
        goto(c + 9);
        check("midreset_en", o_cpuClkEn, 0);
        check("midreset_halted", o_halted, 1);
        check("midreset_bphit", o_breakpointHit, 0);
        goto(c + 10);
        reset_release();
        goto(cyc + 20);
        check("post_reset_halted", o_halted, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
